int_exec_unit: RTL and testbench
================================

// Module: int_exec_unit
// PURPOSE
//  Integer execution unit directly downstream of the integer reservation station.
//  - Consumes one issued op per handshake: {inst_type[9:0], dest[5:0], opr1[31:0], opr2[31:0]}.
//  - Computes single-cycle ALU ops and optional iterative multiplies.
//  - Queues results and broadcasts {tag[5:0], value[31:0]} onto the CDB under a req/grant handshake.
// PARAMETERS
//  OBUF_DEPTH  2   result buffer entries; power of two, >=2
// PORTS
//  clk        in   1   system clock; all state updates on posedge
//  reset      in   1   synchronous, active-high
//  ex_en      in   1   RS presents a ready op on rs2exe
//  rs2exe     in   80  {inst_type[79:70], dest[69:64], opr1[63:32], opr2[31:0]}
//  ex_ready   out  1   unit accepts an op this cycle
//  cdb_req    out  1   buffer head valid, requesting the CDB
//  cdb_grant  in   1   CDB arbiter accepts the head this cycle
//  cdb_out    out  38  {dest[37:32], result[31:0]} of the buffer head; 38'b0 when empty
// BEHAVIOUR
//  - Clocking: one clock, clk. reset is synchronous and active-high.
//  - Accept: ex_en && ex_ready at a posedge.
//    - ex_ready = (state==IDLE) && !buf_full.
//    - ex_ready is registered-state only; it never depends on cdb_grant.
//  - Opcode: inst_type[3:0]; inst_type[9:4] ignored.
//    - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
//    - 10 MUL (low 32), 11 MULH (signed x signed, high 32), 12 MULHU (unsigned, high 32)
//    - 13-15 reserved: result 32'h0, ALU timing.
//  - Arithmetic: ADD/SUB wrap mod 2^32. Shift amount = opr2[4:0]. SLT/SLTU yield 32'h1 or 32'h0.
//  - ALU op: result pushed into the buffer on the accept edge; cdb_req is high the next cycle.
//  - FSM: IDLE -> MUL on accepting op 10-12; MUL -> DONE after 32 iterations; DONE -> IDLE.
//    - MUL: operands latched at accept. MULH uses magnitudes, with the sign fixed on the 64-bit product.
//    - 32 radix-2 shift-add iteration edges follow the accept; a 5-bit counter counts 0..31.
//    - DONE: pushes the product and returns to IDLE on the same edge (33rd edge after accept).
//    - Space is guaranteed: nothing else is accepted while state!=IDLE, and the buffer only drains.
//  - Buffer: FIFO, OBUF_DEPTH entries, wrapping rd/wr pointers plus a count.
//    - Pop on cdb_req && cdb_grant.
//    - Push and pop on the same edge keep the count unchanged.
//    - cdb_grant while empty is ignored.
//    - Results leave the unit in acceptance order.
//  - Reset (any time, including mid-multiply):
//    - state=IDLE, counter=0, buffer emptied, in-flight op dropped.
//    - Outputs: ex_ready=1, cdb_req=0, cdb_out=38'b0.
// CONFIGURATION
//  INT_EXU_MUL_EN
//    - Defined: multiplier datapath, MUL/DONE states and opcodes 10-12 are present as above.
//    - Undefined: multiplier and FSM are compiled out (unit always IDLE).
//      Opcodes 10-12 act as reserved: result 32'h0, ALU timing.
// TESTING
//  T1 reset, no ex_en -> ex_ready=1, cdb_req=0, cdb_out=38'b0
//  T2 ADD dest=5, 7+(-3); grant held high -> next cycle cdb_out={6'd5,32'd4}, popped; cdb_req then 0
//  T3 SRA 32'h80000000 by 4, then SLTU 1<2, grant low -> cdb_req=1, ex_ready=0 after 2 pushes;
//     1st grant -> {d,32'hF8000000}, 2nd grant -> {d,32'h1}
//  T4 [MUL_EN] MULH dest=9, 32'hFFFFFFFE x 32'h3 -> ex_ready=0 for 33 cycles;
//     cdb_out={6'd9,32'hFFFFFFFF} after the 33rd edge
//  T5 [MUL_EN] reset asserted at iteration 10 of a MUL -> no result ever appears;
//     ex_ready=1 the cycle after reset
//  T6 [no MUL_EN] MUL 3x4 -> ALU timing, result 32'h0; simultaneous push+pop at count 1 leaves count 1

Source files
------------

// File: rtl/int_exec_unit.sv
// int_exec_unit: single-cycle integer ALU plus optional radix-2 multiplier feeding an in-order CDB result FIFO.
// Define INT_EXU_MUL_EN to build the multiplier (opcodes 10-12); otherwise those opcodes return zero like reserved ones.
module int_exec_unit #(
  parameter int OBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_en,
  input  logic [79:0] rs2exe,
  output logic        ex_ready,
  output logic        cdb_req,
  input  logic        cdb_grant,
  output logic [37:0] cdb_out
);

  localparam int PTR_W = $clog2(OBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OBUF_DEPTH);

  logic [3:0]  op;
  logic [5:0]  dest;
  logic [31:0] opr1;
  logic [31:0] opr2;
  logic        unused_inst_bits;

  assign op   = rs2exe[73:70];
  assign dest = rs2exe[69:64];
  assign opr1 = rs2exe[63:32];
  assign opr2 = rs2exe[31:0];
  assign unused_inst_bits = ^rs2exe[79:74];

  logic        accept;
  logic        push;
  logic        pop;
  logic        buf_full;
  logic [37:0] push_data;
  logic [31:0] alu_result;

  assign accept = ex_en && ex_ready;

  always_comb begin
    alu_result = 32'h0;
    case (op)
      4'd0:    alu_result = opr1 + opr2;
      4'd1:    alu_result = opr1 - opr2;
      4'd2:    alu_result = opr1 << opr2[4:0];
      4'd3:    alu_result = {31'h0, $signed(opr1) < $signed(opr2)};
      4'd4:    alu_result = {31'h0, opr1 < opr2};
      4'd5:    alu_result = opr1 ^ opr2;
      4'd6:    alu_result = opr1 >> opr2[4:0];
      4'd7:    alu_result = 32'($signed(opr1) >>> opr2[4:0]);
      4'd8:    alu_result = opr1 | opr2;
      4'd9:    alu_result = opr1 & opr2;
      default: alu_result = 32'h0;
    endcase
  end

`ifdef INT_EXU_MUL_EN
  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  iter_q, iter_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] mcand_q, mcand_d;
  logic        neg_q, neg_d;
  logic        hi_q, hi_d;
  logic [5:0]  mdest_q, mdest_d;

  logic        is_mul;
  logic        is_mulh;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [32:0] step_sum;
  logic [63:0] prod_signed;

  assign is_mul   = (op == 4'd10) || (op == 4'd11) || (op == 4'd12);
  assign is_mulh  = (op == 4'd11);
  // MULH multiplies magnitudes and restores the sign on the full 64-bit product
  assign mag1     = (is_mulh && opr1[31]) ? -opr1 : opr1;
  assign mag2     = (is_mulh && opr2[31]) ? -opr2 : opr2;
  assign step_sum = {1'b0, prod_q[63:32]} + {1'b0, prod_q[0] ? mcand_q : 32'h0};
  assign prod_signed = neg_q ? -prod_q : prod_q;
  assign ex_ready = (state_q == IDLE) && !buf_full;

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    neg_d     = neg_q;
    hi_d      = hi_q;
    mdest_d   = mdest_q;
    push      = 1'b0;
    push_data = 38'h0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d = MUL;
            iter_d  = 5'd0;
            mcand_d = mag1;
            prod_d  = {32'h0, mag2};
            neg_d   = is_mulh && (opr1[31] ^ opr2[31]);
            hi_d    = (op != 4'd10);
            mdest_d = dest;
          end else begin
            push      = 1'b1;
            push_data = {dest, alu_result};
          end
        end
      end
      MUL: begin
        // Multiplier bits are consumed from the low half as the partial sum shifts in from the top
        prod_d = {step_sum, prod_q[31:1]};
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'd31) begin
          state_d = DONE;
        end
      end
      DONE: begin
        push      = 1'b1;
        push_data = {mdest_q, hi_q ? prod_signed[63:32] : prod_signed[31:0]};
        state_d   = IDLE;
        iter_d    = 5'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      iter_q  <= 5'd0;
      prod_q  <= 64'h0;
      mcand_q <= 32'h0;
      neg_q   <= 1'b0;
      hi_q    <= 1'b0;
      mdest_q <= 6'h0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      mdest_q <= mdest_d;
    end
  end
`else
  assign ex_ready = !buf_full;

  always_comb begin
    push      = accept;
    push_data = {dest, alu_result};
  end
`endif

  logic [37:0]      mem_q [OBUF_DEPTH];
  logic [37:0]      mem_d [OBUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign buf_full = (count_q == FULL_CNT);
  assign cdb_req  = (count_q != '0);
  assign pop      = cdb_req && cdb_grant;
  assign cdb_out  = cdb_req ? mem_q[rd_ptr_q] : 38'h0;

  // Pointers wrap naturally because the depth is a power of two
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_int_exec_unit.sv
// tb_int_exec_unit: table-driven vectors and multi-cycle sequences for int_exec_unit with a CDB scoreboard.
// Multiplier sequences are compiled when INT_EXU_MUL_EN is defined.
module tb_int_exec_unit;

  logic        clk;
  logic        reset;
  logic        ex_en;
  logic [79:0] rs2exe;
  logic        ex_ready;
  logic        cdb_req;
  logic        cdb_grant;
  logic [37:0] cdb_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [37:0] exp_q[$];
  logic [37:0] mon_exp;

  typedef struct {
    logic [9:0]  it;
    logic [5:0]  d;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[$];

  int_exec_unit #(.OBUF_DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .ex_en     (ex_en),
    .rs2exe    (rs2exe),
    .ex_ready  (ex_ready),
    .cdb_req   (cdb_req),
    .cdb_grant (cdb_grant),
    .cdb_out   (cdb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [37:0] actual, input logic [37:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Holds ex_en until the unit accepts, records the expected broadcast, returns 1ns after the accept edge
  task automatic applyStimulus(input logic [9:0] it, input logic [5:0] d, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] res);
    bit accepted;
    accepted = 1'b0;
    ex_en  = 1'b1;
    rs2exe = {it, d, a, b};
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ex_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: got ex_ready=0, expected 1 within 200 cycles");
      ex_en = 1'b0;
      return;
    end
    exp_q.push_back({d, res});
    @(posedge clk);
    #1 ex_en = 1'b0;
  endtask

  task automatic drainAll();
    cdb_grant = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !cdb_req) break;
    end
    checkOutput("drain_queue_empty", 38'(exp_q.size()), 38'h0);
    checkOutput("drain_req_low", {37'h0, cdb_req}, 38'h0);
    @(posedge clk);
    #1 cdb_grant = 1'b0;
  endtask

  // Scoreboard: every granted head must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && cdb_req && cdb_grant) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL cdb_unexpected: got %h, expected no result", cdb_out);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("cdb_out", cdb_out, mon_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy;
    int early_req;
    int stray_req;

    reset     = 1'b1;
    ex_en     = 1'b0;
    cdb_grant = 1'b0;
    rs2exe    = 80'h0;

    vecs.push_back('{it: 10'd0,   d: 6'd1,  a: 32'd7,        b: 32'hFFFFFFFD, res: 32'd4});
    vecs.push_back('{it: 10'd0,   d: 6'd2,  a: 32'hFFFFFFFF, b: 32'd2,        res: 32'd1});
    vecs.push_back('{it: 10'd1,   d: 6'd3,  a: 32'd5,        b: 32'd7,        res: 32'hFFFFFFFE});
    vecs.push_back('{it: 10'd2,   d: 6'd4,  a: 32'd3,        b: 32'h21,       res: 32'd6});
    vecs.push_back('{it: 10'd3,   d: 6'd5,  a: 32'hFFFFFFFF, b: 32'd1,        res: 32'd1});
    vecs.push_back('{it: 10'd4,   d: 6'd6,  a: 32'hFFFFFFFF, b: 32'd1,        res: 32'd0});
    vecs.push_back('{it: 10'd5,   d: 6'd7,  a: 32'hF0F0F0F0, b: 32'hFF00FF00, res: 32'h0FF00FF0});
    vecs.push_back('{it: 10'd6,   d: 6'd8,  a: 32'h80000000, b: 32'd4,        res: 32'h08000000});
    vecs.push_back('{it: 10'd7,   d: 6'd9,  a: 32'h80000000, b: 32'd4,        res: 32'hF8000000});
    vecs.push_back('{it: 10'd8,   d: 6'd10, a: 32'h12340000, b: 32'h00005678, res: 32'h12345678});
    vecs.push_back('{it: 10'd9,   d: 6'd11, a: 32'hFFFF0000, b: 32'h12345678, res: 32'h12340000});
    vecs.push_back('{it: 10'd13,  d: 6'd12, a: 32'd9,        b: 32'd9,        res: 32'd0});
    vecs.push_back('{it: 10'd15,  d: 6'd13, a: 32'hFFFFFFFF, b: 32'd1,        res: 32'd0});
    vecs.push_back('{it: 10'h3F0, d: 6'd14, a: 32'd10,       b: 32'd20,       res: 32'h1E});
    vecs.push_back('{it: 10'd3,   d: 6'd15, a: 32'd5,        b: 32'd5,        res: 32'd0});
`ifdef INT_EXU_MUL_EN
    vecs.push_back('{it: 10'd10,  d: 6'd16, a: 32'd3,        b: 32'd4,        res: 32'd12});
    vecs.push_back('{it: 10'd10,  d: 6'd17, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, res: 32'd1});
    vecs.push_back('{it: 10'd11,  d: 6'd18, a: 32'hFFFFFFFE, b: 32'd3,        res: 32'hFFFFFFFF});
    vecs.push_back('{it: 10'd11,  d: 6'd19, a: 32'h80000000, b: 32'h80000000, res: 32'h40000000});
    vecs.push_back('{it: 10'd12,  d: 6'd20, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, res: 32'hFFFFFFFE});
    vecs.push_back('{it: 10'd11,  d: 6'd21, a: 32'h7FFFFFFF, b: 32'h7FFFFFFF, res: 32'h3FFFFFFF});
    vecs.push_back('{it: 10'd11,  d: 6'd22, a: 32'd7,        b: 32'hFFFFFFFF, res: 32'hFFFFFFFF});
    vecs.push_back('{it: 10'd11,  d: 6'd23, a: 32'd0,        b: 32'hFFFFFFFB, res: 32'd0});
`else
    vecs.push_back('{it: 10'd10,  d: 6'd16, a: 32'd3,        b: 32'd4,        res: 32'd0});
    vecs.push_back('{it: 10'd11,  d: 6'd17, a: 32'hFFFFFFFE, b: 32'd3,        res: 32'd0});
    vecs.push_back('{it: 10'd12,  d: 6'd18, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, res: 32'd0});
`endif

    // Reset with no traffic
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("t1_ex_ready", {37'h0, ex_ready}, 38'h1);
    checkOutput("t1_cdb_req", {37'h0, cdb_req}, 38'h0);
    checkOutput("t1_cdb_out", cdb_out, 38'h0);
    @(posedge clk);
    #1;

    // Single ADD with grant held high
    cdb_grant = 1'b1;
    applyStimulus(10'd0, 6'd5, 32'd7, 32'hFFFFFFFD, 32'd4);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t2_req_after_pop", {37'h0, cdb_req}, 38'h0);
    @(posedge clk);
    #1;

    // Back-to-back table vectors, scoreboard checks each broadcast
    cdb_grant = 1'b1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].it, vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].res);
    end
    drainAll();

    // Fill the buffer with grant low, then release one entry at a time
    cdb_grant = 1'b0;
    applyStimulus(10'd7, 6'd20, 32'h80000000, 32'd4, 32'hF8000000);
    applyStimulus(10'd4, 6'd21, 32'd1, 32'd2, 32'd1);
    @(negedge clk);
    checkOutput("t3_req_full", {37'h0, cdb_req}, 38'h1);
    checkOutput("t3_ready_full", {37'h0, ex_ready}, 38'h0);
    checkOutput("t3_head_first", cdb_out, {6'd20, 32'hF8000000});
    @(posedge clk);
    #1 cdb_grant = 1'b1;
    @(posedge clk);
    #1 cdb_grant = 1'b0;
    @(negedge clk);
    checkOutput("t3_ready_after_pop", {37'h0, ex_ready}, 38'h1);
    checkOutput("t3_head_second", cdb_out, {6'd21, 32'h1});
    @(posedge clk);
    #1 cdb_grant = 1'b1;
    @(posedge clk);
    #1 cdb_grant = 1'b0;
    @(negedge clk);
    checkOutput("t3_req_empty", {37'h0, cdb_req}, 38'h0);
    @(posedge clk);
    #1;

    // Grant on an empty buffer must not disturb later results
    cdb_grant = 1'b1;
    repeat (3) @(posedge clk);
    #1 cdb_grant = 1'b0;
    applyStimulus(10'd0, 6'd22, 32'd100, 32'd23, 32'd123);
    @(negedge clk);
    checkOutput("empty_grant_req", {37'h0, cdb_req}, 38'h1);
    checkOutput("empty_grant_head", cdb_out, {6'd22, 32'd123});
    @(posedge clk);
    #1;
    drainAll();

    // Simultaneous push and pop at count 1
    cdb_grant = 1'b0;
`ifdef INT_EXU_MUL_EN
    applyStimulus(10'd5, 6'd30, 32'd3, 32'd4, 32'd7);
    @(negedge clk);
    checkOutput("t6_first_head", cdb_out, {6'd30, 32'd7});
`else
    applyStimulus(10'd10, 6'd30, 32'd3, 32'd4, 32'd0);
    @(negedge clk);
    checkOutput("t6_mul_alu_timing", cdb_out, {6'd30, 32'd0});
`endif
    checkOutput("t6_first_req", {37'h0, cdb_req}, 38'h1);
    @(posedge clk);
    #1 cdb_grant = 1'b1;
    applyStimulus(10'd0, 6'd31, 32'd1, 32'd1, 32'd2);
    cdb_grant = 1'b0;
    @(negedge clk);
    checkOutput("t6_req_kept", {37'h0, cdb_req}, 38'h1);
    checkOutput("t6_ready_kept", {37'h0, ex_ready}, 38'h1);
    checkOutput("t6_head_second", cdb_out, {6'd31, 32'd2});
    @(posedge clk);
    #1;
    drainAll();

`ifdef INT_EXU_MUL_EN
    // MULH latency: 33 busy cycles, result visible right after
    cdb_grant = 1'b0;
    applyStimulus(10'd11, 6'd9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF);
    busy = 0;
    early_req = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ex_ready) break;
      busy++;
      if (cdb_req) early_req++;
    end
    checkOutput("t4_busy_cycles", 38'(busy), 38'd33);
    checkOutput("t4_early_req", 38'(early_req), 38'd0);
    checkOutput("t4_req", {37'h0, cdb_req}, 38'h1);
    checkOutput("t4_result", cdb_out, {6'd9, 32'hFFFFFFFF});
    @(posedge clk);
    #1;
    drainAll();

    // Reset sampled on the edge that would run iteration 10
    cdb_grant = 1'b0;
    applyStimulus(10'd10, 6'd12, 32'd5, 32'd6, 32'd30);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete(exp_q.size() - 1);
    @(negedge clk);
    checkOutput("t5_ready", {37'h0, ex_ready}, 38'h1);
    checkOutput("t5_req", {37'h0, cdb_req}, 38'h0);
    checkOutput("t5_out", cdb_out, 38'h0);
    @(posedge clk);
    #1 cdb_grant = 1'b1;
    stray_req = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cdb_req) stray_req++;
    end
    checkOutput("t5_no_result", 38'(stray_req), 38'd0);
    @(posedge clk);
    #1 cdb_grant = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
